// File: rtl/mcp_capture_ctrl.sv
// Multicycle launch/capture sequencer: a clock-enable schedule moves data from a
// source register to a destination register a programmable number of cycles later.
module mcp_capture_ctrl #(
  parameter int DATA_W = 8,
  parameter int MCP_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [MCP_W-1:0]  cfg_setup,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              launch_en,
  output logic              capture_en,
  output logic              busy,
  output logic              cfg_err,
  output logic [15:0]       xfer_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_OUT  = 2'd2
  } state_t;

  state_t            state_r;
  logic [DATA_W-1:0] src_r;
  logic [DATA_W-1:0] dst_r;
  logic [MCP_W-1:0]  cnt_r;
  logic [15:0]       xfer_cnt_r;
  logic              cfg_err_r;
  logic              cnt_zero_s;

  assign cnt_zero_s = (cnt_r == {MCP_W{1'b0}});

  // The enables define the multicycle path for STA; flush suppresses both in its cycle.
  assign launch_en  = (state_r == ST_IDLE) & in_valid & ~flush & ~rst;
  assign capture_en = (state_r == ST_WAIT) & cnt_zero_s & ~flush;

  assign in_ready  = (state_r == ST_IDLE);
  assign out_valid = (state_r == ST_OUT);
  assign busy      = (state_r != ST_IDLE);
  assign out_data  = dst_r;
  assign cfg_err   = cfg_err_r;
  assign xfer_cnt  = xfer_cnt_r;

  // Transfer sequencer: launch, count down the setup window, capture, hand off.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      src_r      <= {DATA_W{1'b0}};
      dst_r      <= {DATA_W{1'b0}};
      cnt_r      <= {MCP_W{1'b0}};
      xfer_cnt_r <= 16'd0;
      cfg_err_r  <= 1'b0;
    end else if (flush) begin
      state_r <= ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (in_valid) begin
            src_r   <= in_data;
            state_r <= ST_WAIT;
            // A zero multiplier is treated as a single-cycle path and flagged.
            if (cfg_setup == {MCP_W{1'b0}}) begin
              cnt_r     <= {MCP_W{1'b0}};
              cfg_err_r <= 1'b1;
            end else begin
              cnt_r <= cfg_setup - MCP_W'(1);
            end
          end
        end
        ST_WAIT: begin
          if (cnt_zero_s) begin
            dst_r   <= src_r;
            state_r <= ST_OUT;
          end else begin
            cnt_r <= cnt_r - MCP_W'(1);
          end
        end
        ST_OUT: begin
          if (out_ready) begin
            state_r    <= ST_IDLE;
            xfer_cnt_r <= xfer_cnt_r + 16'd1;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mcp_capture_ctrl.sv
// Directed self-checking bench for mcp_capture_ctrl.
module tb_mcp_capture_ctrl;

  logic        clk;
  logic        rst;
  logic [3:0]  cfg_setup;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic        launch_en;
  logic        capture_en;
  logic        busy;
  logic        cfg_err;
  logic [15:0] xfer_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  mcp_capture_ctrl #(.DATA_W(8), .MCP_W(4)) dut (
    .clk(clk), .rst(rst), .cfg_setup(cfg_setup), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .launch_en(launch_en), .capture_en(capture_en), .busy(busy),
    .cfg_err(cfg_err), .xfer_cnt(xfer_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    in_valid = 1'b1;
    #2;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_checks++; if (launch_en !== 1'b0) begin n_fail++; $display("FAIL reset_launch_en: got %b want 0", launch_en); end
    n_checks++; if (capture_en !== 1'b0) begin n_fail++; $display("FAIL reset_capture_en: got %b want 0", capture_en); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (out_data !== 8'h00) begin n_fail++; $display("FAIL reset_out_data: got %h want 00", out_data); end
    n_checks++; if (xfer_cnt !== 16'h0000) begin n_fail++; $display("FAIL reset_xfer_cnt: got %h want 0000", xfer_cnt); end
    n_checks++; if (cfg_err !== 1'b0) begin n_fail++; $display("FAIL reset_cfg_err: got %b want 0", cfg_err); end
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_n1();
    cfg_setup = 4'd1; in_data = 8'hA5; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    n_checks++; if (launch_en !== 1'b1) begin n_fail++; $display("FAIL n1_launch_en: got %b want 1", launch_en); end
    @(negedge clk);
    in_valid = 1'b0;
    n_checks++; if (capture_en !== 1'b1) begin n_fail++; $display("FAIL n1_capture_en: got %b want 1", capture_en); end
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL n1_in_ready_wait: got %b want 0", in_ready); end
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL n1_out_valid: got %b want 1", out_valid); end
    n_checks++; if (out_data !== 8'hA5) begin n_fail++; $display("FAIL n1_out_data: got %h want a5", out_data); end
    @(negedge clk);
    n_checks++; if (xfer_cnt !== 16'd1) begin n_fail++; $display("FAIL n1_xfer_cnt: got %0d want 1", xfer_cnt); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL n1_idle: got busy %b want 0", busy); end
  endtask

  task automatic test_n3_backpressure();
    cfg_setup = 4'd3; in_data = 8'h3C; in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    // Disturb config and input while waiting; neither may reach the capture.
    in_valid = 1'b0; cfg_setup = 4'd1; in_data = 8'hFF;
    for (int c = 0; c < 3; c++) begin
      n_checks++; if (capture_en !== (c == 2)) begin n_fail++; $display("FAIL n3_capture_en c=%0d: got %b want %b", c, capture_en, (c == 2)); end
      n_checks++; if (out_data !== 8'hA5) begin n_fail++; $display("FAIL n3_dst_hold c=%0d: got %h want a5", c, out_data); end
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL n3_out_valid_early c=%0d: got %b want 0", c, out_valid); end
      @(negedge clk);
    end
    in_valid = 1'b1; in_data = 8'h11;
    #1;
    for (int i = 0; i < 5; i++) begin
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_out_valid i=%0d: got %b want 1", i, out_valid); end
      n_checks++; if (out_data !== 8'h3C) begin n_fail++; $display("FAIL bp_out_data i=%0d: got %h want 3c", i, out_data); end
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready i=%0d: got %b want 0", i, in_ready); end
      n_checks++; if (launch_en !== 1'b0) begin n_fail++; $display("FAIL bp_launch_en i=%0d: got %b want 0", i, launch_en); end
      @(negedge clk);
    end
    out_ready = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    n_checks++; if (xfer_cnt !== 16'd2) begin n_fail++; $display("FAIL bp_xfer_cnt: got %0d want 2", xfer_cnt); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL bp_idle: got busy %b want 0", busy); end
  endtask

  task automatic test_cfg_zero();
    logic [7:0] d;
    cfg_setup = 4'd0; in_data = 8'h5A; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    n_checks++; if (capture_en !== 1'b1) begin n_fail++; $display("FAIL z_capture_en: got %b want 1", capture_en); end
    n_checks++; if (cfg_err !== 1'b1) begin n_fail++; $display("FAIL z_cfg_err: got %b want 1", cfg_err); end
    @(negedge clk);
    n_checks++; if (out_data !== 8'h5A) begin n_fail++; $display("FAIL z_out_data: got %h want 5a", out_data); end
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      d = (k == 0) ? 8'hB4 : 8'hC3;
      cfg_setup = 4'd2; in_data = d; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      n_checks++; if (capture_en !== 1'b0) begin n_fail++; $display("FAIL z2_capture_early k=%0d: got %b want 0", k, capture_en); end
      @(negedge clk);
      n_checks++; if (capture_en !== 1'b1) begin n_fail++; $display("FAIL z2_capture_en k=%0d: got %b want 1", k, capture_en); end
      @(negedge clk);
      n_checks++; if (out_data !== d) begin n_fail++; $display("FAIL z2_out_data k=%0d: got %h want %h", k, out_data, d); end
      @(negedge clk);
      n_checks++; if (xfer_cnt !== 16'(4 + k)) begin n_fail++; $display("FAIL z2_xfer_cnt k=%0d: got %0d want %0d", k, xfer_cnt, 4 + k); end
      n_checks++; if (cfg_err !== 1'b1) begin n_fail++; $display("FAIL z2_cfg_err_sticky k=%0d: got %b want 1", k, cfg_err); end
    end
  endtask

  task automatic test_flush();
    cfg_setup = 4'd4; in_data = 8'h77; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    for (int c = 0; c < 3; c++) @(negedge clk);
    n_checks++; if (capture_en !== 1'b1) begin n_fail++; $display("FAIL fl_capture_due: got %b want 1", capture_en); end
    flush = 1'b1;
    #1;
    n_checks++; if (capture_en !== 1'b0) begin n_fail++; $display("FAIL fl_capture_forced: got %b want 0", capture_en); end
    @(negedge clk);
    flush = 1'b0;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL fl_idle: got busy %b want 0", busy); end
    n_checks++; if (out_data !== 8'hC3) begin n_fail++; $display("FAIL fl_no_capture: got %h want c3", out_data); end
    n_checks++; if (xfer_cnt !== 16'd5) begin n_fail++; $display("FAIL fl_xfer_cnt: got %0d want 5", xfer_cnt); end
    // Flush while presenting output with out_ready high: not counted, data retained.
    cfg_setup = 4'd1; in_data = 8'h99; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL fl_out_idle: got busy %b want 0", busy); end
    n_checks++; if (out_data !== 8'h99) begin n_fail++; $display("FAIL fl_out_data_kept: got %h want 99", out_data); end
    n_checks++; if (xfer_cnt !== 16'd5) begin n_fail++; $display("FAIL fl_out_uncounted: got %0d want 5", xfer_cnt); end
  endtask

  task automatic test_rst_wait();
    cfg_setup = 4'd3; in_data = 8'h42; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rw_busy: got %b want 0", busy); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rw_in_ready: got %b want 1", in_ready); end
    n_checks++; if (out_data !== 8'h00) begin n_fail++; $display("FAIL rw_out_data: got %h want 00", out_data); end
    n_checks++; if (xfer_cnt !== 16'd0) begin n_fail++; $display("FAIL rw_xfer_cnt: got %0d want 0", xfer_cnt); end
    n_checks++; if (cfg_err !== 1'b0) begin n_fail++; $display("FAIL rw_cfg_err: got %b want 0", cfg_err); end
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      n_checks++; if (capture_en !== 1'b0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL rw_no_capture c=%0d: got cap %b ov %b want 0 0", c, capture_en, out_valid); end
      @(negedge clk);
    end
  endtask

  task automatic test_wrap();
    force dut.xfer_cnt_r = 16'hFFFD;
    #1;
    release dut.xfer_cnt_r;
    cfg_setup = 4'd1; in_data = 8'hE1; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    for (int c = 0; c < 9; c++) begin
      n_checks++; if (launch_en !== (c % 3 == 0)) begin n_fail++; $display("FAIL wr_period c=%0d: got launch %b want %b", c, launch_en, (c % 3 == 0)); end
      if (c == 3) begin
        n_checks++; if (xfer_cnt !== 16'hFFFE) begin n_fail++; $display("FAIL wr_cnt_fffe: got %h want fffe", xfer_cnt); end
      end
      if (c == 6) begin
        n_checks++; if (xfer_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL wr_cnt_ffff: got %h want ffff", xfer_cnt); end
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    n_checks++; if (xfer_cnt !== 16'h0000) begin n_fail++; $display("FAIL wr_cnt_wrap: got %h want 0000", xfer_cnt); end
    n_checks++; if (out_data !== 8'hE1) begin n_fail++; $display("FAIL wr_out_data: got %h want e1", out_data); end
  endtask

  initial begin
    rst = 1'b1; cfg_setup = 4'd0; flush = 1'b0;
    in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
    test_reset();
    test_n1();
    test_n3_backpressure();
    test_cfg_zero();
    test_flush();
    test_rst_wait();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
